// File: rtl/level_sequencer.sv
// Level-progression controller for the block stacker: arms, plays, wins or loses each level.
// Optional high-score register is built when BLOCKSTACKER_HISCORE_EN is defined.
module level_sequencer #(
    parameter int NUM_LEVELS   = 15,
    parameter int BASE_SPEED   = 60,
    parameter int SPEED_STEP   = 4,
    parameter int MIN_SPEED    = 8,
    parameter int START_BLOCKS = 3,
    parameter int SHRINK_EVERY = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        go,
    input  logic        result_valid,
    input  logic        result_hit,
    output logic [10:0] speed_count,
    output logic [3:0]  num_blocks,
    output logic [5:0]  curr_level,
    output logic        playing,
    output logic        game_won,
    output logic        game_over,
    output logic [5:0]  best_level
);

    // state | meaning
    // WAIT  | idle between levels, waiting for a go press
    // ARM   | go pressed, waiting for release
    // PLAY  | mover running, waiting for the lander result
    // WIN   | last level cleared, game_won pulse
    // LOSE  | miss, game_over pulse
    typedef enum logic [2:0] {S_WAIT, S_ARM, S_PLAY, S_WIN, S_LOSE} state_t;

    localparam int SHW = (SHRINK_EVERY > 1) ? $clog2(SHRINK_EVERY) : 1;
    localparam logic [11:0] SAT_THRESH = 12'(MIN_SPEED + SPEED_STEP);

    if (NUM_LEVELS < 2 || NUM_LEVELS > 63)
        $error("NUM_LEVELS must be 2..63");
    if (BASE_SPEED < 1 || BASE_SPEED > 2047 || MIN_SPEED < 1 || MIN_SPEED > 2047)
        $error("BASE_SPEED/MIN_SPEED must fit 11 bits and be >= 1");
    if (SPEED_STEP < 0 || SPEED_STEP > 2047 || MIN_SPEED + SPEED_STEP > 4095)
        $error("SPEED_STEP must fit 11 bits");
    if (START_BLOCKS < 1 || START_BLOCKS > 15)
        $error("START_BLOCKS must be 1..15");
    if (SHRINK_EVERY < 1)
        $error("SHRINK_EVERY must be >= 1");

    state_t          state, state_next;
    logic [SHW-1:0]  shrink_cnt;
    logic            level_up;
    logic            win_now;
    logic [10:0]     speed_dec;

    always_ff @(posedge clk) begin
        if (resetn) state <= S_WAIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        level_up   = 1'b0;
        win_now    = 1'b0;
        case (state)
            S_WAIT: if (go) state_next = S_ARM;
            S_ARM:  if (!go) state_next = S_PLAY;
            S_PLAY: begin
                if (result_valid) begin
                    if (!result_hit) begin
                        state_next = S_LOSE;
                    end else if (curr_level == 6'(NUM_LEVELS)) begin
                        state_next = S_WIN;
                        win_now    = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        level_up   = 1'b1;
                    end
                end
            end
            S_WIN:   state_next = S_WAIT;
            S_LOSE:  state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    // Saturating decrement: never drop below the floor, never wrap.
    always_comb begin
        if ({1'b0, speed_count} >= SAT_THRESH) speed_dec = speed_count - 11'(SPEED_STEP);
        else                                   speed_dec = 11'(MIN_SPEED);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            curr_level  <= 6'd1;
            speed_count <= 11'(BASE_SPEED);
            num_blocks  <= 4'(START_BLOCKS);
            shrink_cnt  <= '0;
            playing     <= 1'b0;
            game_won    <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            playing   <= (state_next == S_PLAY);
            game_won  <= (state_next == S_WIN);
            game_over <= (state_next == S_LOSE);
            if (state == S_WIN || state == S_LOSE) begin
                curr_level  <= 6'd1;
                speed_count <= 11'(BASE_SPEED);
                num_blocks  <= 4'(START_BLOCKS);
                shrink_cnt  <= '0;
            end else if (level_up) begin
                curr_level  <= curr_level + 6'd1;
                speed_count <= speed_dec;
                if (shrink_cnt == SHW'(SHRINK_EVERY - 1)) begin
                    shrink_cnt <= '0;
                    num_blocks <= (num_blocks > 4'd1) ? num_blocks - 4'd1 : 4'd1;
                end else begin
                    shrink_cnt <= shrink_cnt + 1'b1;
                end
            end
        end
    end

`ifdef BLOCKSTACKER_HISCORE_EN
    always_ff @(posedge clk) begin
        if (resetn)
            best_level <= 6'd0;
        else if ((level_up || win_now) && curr_level > best_level)
            best_level <= curr_level;
    end
`else
    assign best_level = 6'd0;
`endif

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with default parameters and hand-computed expectations.
// High-score expectations follow BLOCKSTACKER_HISCORE_EN as seen by the bench.
module tb_level_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        go = 1'b0;
    logic        result_valid = 1'b0;
    logic        result_hit = 1'b0;
    logic [10:0] speed_count;
    logic [3:0]  num_blocks;
    logic [5:0]  curr_level;
    logic        playing;
    logic        game_won;
    logic        game_over;
    logic [5:0]  best_level;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    level_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .go           (go),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .speed_count  (speed_count),
        .num_blocks   (num_blocks),
        .curr_level   (curr_level),
        .playing      (playing),
        .game_won     (game_won),
        .game_over    (game_over),
        .best_level   (best_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm_and_play();
        go = 1'b1;
        step(1);
        go = 1'b0;
        step(1);
    endtask

    task automatic strobe(input logic hit);
        result_valid = 1'b1;
        result_hit   = hit;
        step(1);
        result_valid = 1'b0;
        result_hit   = 1'b0;
    endtask

    task automatic clear_levels(input int n);
        for (int i = 0; i < n; i++) begin
            arm_and_play();
            strobe(1'b1);
        end
    endtask

    task automatic check_best(input string tag, input int exp_hs);
`ifdef BLOCKSTACKER_HISCORE_EN
        check(tag, 32'(best_level), 32'(exp_hs));
`else
        check(tag, 32'(best_level), 32'd0);
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        step(2);
        resetn = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_level", 32'(curr_level), 1);
        check("rst_speed", 32'(speed_count), 60);
        check("rst_blocks", 32'(num_blocks), 3);
        check("rst_playing", 32'(playing), 0);
        check("rst_won", 32'(game_won), 0);
        check("rst_over", 32'(game_over), 0);
        check_best("rst_best", 0);

        go = 1'b1;
        step(10);
        check("hold_go_arm", 32'(playing), 0);
        go = 1'b0;
        step(1);
        check("release_play", 32'(playing), 1);
        strobe(1'b1);
        check("l2_level", 32'(curr_level), 2);
        check("l2_speed", 32'(speed_count), 56);
        check("l2_blocks", 32'(num_blocks), 3);
        check("l2_playing", 32'(playing), 0);

        clear_levels(4);
        check("l6_level", 32'(curr_level), 6);
        check("l6_speed", 32'(speed_count), 40);
        check("l6_blocks", 32'(num_blocks), 2);
        clear_levels(4);
        check("l10_blocks", 32'(num_blocks), 2);
        clear_levels(1);
        check("l11_speed", 32'(speed_count), 20);
        check("l11_blocks", 32'(num_blocks), 1);
        clear_levels(3);
        check("l14_speed", 32'(speed_count), 8);
        clear_levels(1);
        check("l15_level", 32'(curr_level), 15);
        check("l15_speed", 32'(speed_count), 8);
        check("l15_blocks", 32'(num_blocks), 1);
        check_best("l15_best", 14);

        arm_and_play();
        strobe(1'b1);
        check("win_pulse", 32'(game_won), 1);
        check("win_no_over", 32'(game_over), 0);
        step(1);
        check("win_pulse_end", 32'(game_won), 0);
        check("win_level", 32'(curr_level), 1);
        check("win_speed", 32'(speed_count), 60);
        check("win_blocks", 32'(num_blocks), 3);
        check("win_playing", 32'(playing), 0);
        check_best("win_best", 15);

        strobe(1'b1);
        check("ign_wait_level", 32'(curr_level), 1);
        check("ign_wait_play", 32'(playing), 0);
        go = 1'b1;
        step(1);
        strobe(1'b0);
        check("ign_arm_over", 32'(game_over), 0);
        check("ign_arm_level", 32'(curr_level), 1);
        go = 1'b0;
        step(1);
        check("after_ign_play", 32'(playing), 1);
        strobe(1'b1);

        clear_levels(5);
        check("l7_level", 32'(curr_level), 7);
        arm_and_play();
        strobe(1'b0);
        check("lose_pulse", 32'(game_over), 1);
        check("lose_no_won", 32'(game_won), 0);
        step(1);
        check("lose_pulse_end", 32'(game_over), 0);
        check("lose_level", 32'(curr_level), 1);
        check("lose_speed", 32'(speed_count), 60);

        arm_and_play();
        go = 1'b1;
        strobe(1'b1);
        check("sim_go_level", 32'(curr_level), 2);
        check("sim_go_playing", 32'(playing), 0);
        step(1);
        go = 1'b0;
        step(1);
        check("rearm_play", 32'(playing), 1);
        strobe(1'b1);
        check("rearm_level", 32'(curr_level), 3);

        do_reset();
        check_best("rst2_best", 0);
        clear_levels(8);
        arm_and_play();
        check("l9_level", 32'(curr_level), 9);
        check("l9_playing", 32'(playing), 1);
        check_best("l9_best", 8);
        resetn = 1'b1;
        step(1);
        resetn = 1'b0;
        check("rst_play_level", 32'(curr_level), 1);
        check("rst_play_playing", 32'(playing), 0);
        check_best("rst_play_best", 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
